// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder. Adds two WIDTH-bit operands one bit
//               per clock, LSB first, through a single full-adder cell built
//               from two half adders and an OR, with the carry held in a
//               flip-flop between cycles. Uses a start/busy/done handshake and
//               presents a registered result that is held until the next
//               completion.
//
// Ports       : clk    in   rising-edge clock
//               rst    in   asynchronous, active-high reset
//               start  in   request an addition (sampled only in IDLE)
//               A      in   [WIDTH-1:0] operand A, captured on accept
//               B      in   [WIDTH-1:0] operand B, captured on accept
//               busy   out  high while the serial add is in progress
//               done   out  one-cycle pulse when Sum/C_out are updated
//               Sum    out  [WIDTH-1:0] registered (A+B) mod 2^WIDTH
//               C_out  out  registered carry out of bit WIDTH-1
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8   // operand and sum width, legal range 1..32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             C_out
);

   // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] s_sh_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   // Full-adder cell: two half adders plus an OR on the carries.
   logic             s1;
   logic             c1;
   logic             s_bit;
   logic             c2;
   logic             carry_d;
   logic [WIDTH-1:0] s_sh_d;

   assign s1      = a_sh_q[0] ^ b_sh_q[0];
   assign c1      = a_sh_q[0] & b_sh_q[0];
   assign s_bit   = s1 ^ carry_q;
   assign c2      = s1 & carry_q;
   assign carry_d = c1 | c2;

   // Sum bits enter at the MSB and reach their final position after WIDTH
   // shifts. A one-bit build has nothing to shift through.
   generate
      if (WIDTH == 1) begin : g_sh_w1
         assign s_sh_d = s_bit;
      end else begin : g_sh_wn
         assign s_sh_d = {s_bit, s_sh_q[WIDTH-1:1]};
      end
   endgenerate

   // Bit 0 of the sum shift register is shifted out and never read on its
   // own; the completed word is taken from s_sh_d on the completing edge.
   logic unused_s_sh_lsb;
   assign unused_s_sh_lsb = s_sh_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sh_q  <= A;
                  b_sh_q  <= B;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_BUSY;
               end
            end

            S_BUSY: begin
               carry_q <= carry_d;
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               s_sh_q  <= s_sh_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  // Last bit: publish the result and pulse done next cycle.
                  sum_q   <= s_sh_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               // start is deliberately ignored here; no request is queued.
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign Sum   = sum_q;
   assign C_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder. Drives a
//               WIDTH=8 instance and a WIDTH=1 instance from one clock and
//               compares every output against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   int checks = 0;
   int errors = 0;

   // Bench-side copy of the result the DUT must be holding.
   logic [7:0] held_sum  = 8'h00;
   logic       held_cout = 1'b0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .A     (a8),
      .B     (b8),
      .busy  (busy8),
      .done  (done8),
      .Sum   (sum8),
      .C_out (cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .A     (a1),
      .B     (b1),
      .busy  (busy1),
      .done  (done1),
      .Sum   (sum1),
      .C_out (cout1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 addition from IDLE; done must appear after the 8th edge
   // following the accepting edge (9 edges counting the accept).
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
      int early;
      early = 0;
      a8 = a; b8 = b; start8 = 1'b1;
      tick();                      // accepting edge E0
      start8 = 1'b0;
      a8 = ~a; b8 = ~b;            // operands may change after accept
      check({tag, "_busy_e0"}, 32'(busy8), 32'd1);
      check({tag, "_held_e0"}, {23'd0, cout8, sum8}, {23'd0, held_cout, held_sum});
      for (int i = 1; i < 8; i++) begin
         tick();
         if (done8 !== 1'b0 || busy8 !== 1'b1) early++;
      end
      check({tag, "_early"}, 32'(early), 32'd0);
      tick();                      // edge E0+8
      check({tag, "_done"}, {30'd0, busy8, done8}, {30'd0, 1'b0, 1'b1});
      check({tag, "_sum"}, {23'd0, cout8, sum8}, {23'd0, ec, es});
      held_sum = es; held_cout = ec;
      tick();
      check({tag, "_done_end"}, 32'(done8), 32'd0);
   endtask

   task automatic run1(input string tag, input logic a, input logic b,
                       input logic es, input logic ec);
      a1 = a; b1 = b; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check({tag, "_e0"}, {30'd0, busy1, done1}, {30'd0, 1'b1, 1'b0});
      tick();
      check({tag, "_done"}, {30'd0, busy1, done1}, {30'd0, 1'b0, 1'b1});
      check({tag, "_sum"}, {30'd0, cout1, sum1}, {30'd0, ec, es});
      tick();
      check({tag, "_done_end"}, 32'(done1), 32'd0);
   endtask

   initial begin
      int pulses;
      int overlap;
      int last_cyc;

      // Reset state
      #1;
      check("rst_outputs", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
      check("rst_outputs_w1", {29'd0, busy1, done1, cout1}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Basic sum gives a non-zero held value before the mid-run reset
      run8("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);

      // Reset mid-run, 3 cycles after accept
      a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      check("midrst_outputs", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
      held_sum = 8'h00; held_cout = 1'b0;
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done8 !== 1'b0 || busy8 !== 1'b0) pulses++;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);
      run8("after_rst_01_02", 8'h01, 8'h02, 8'h03, 1'b0);

      run8("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
      run8("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
      run8("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

      // start pulsed during BUSY and during DONE is ignored
      a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) begin
            a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
         end
         tick();
         start8 = 1'b0;
         if (done8 === 1'b1) begin
            pulses++;
            check("ign_sum", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h46});
            a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;   // sampled in DONE
         end
      end
      start8 = 1'b0;
      check("ign_one_done", 32'(pulses), 32'd1);
      check("ign_no_queue", {31'd0, busy8}, 32'd0);
      check("ign_held", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h46});

      // start held high for 30 cycles
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      pulses = 0; overlap = 0; last_cyc = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (busy8 === 1'b1 && done8 === 1'b1) overlap++;
         if (done8 === 1'b1) begin
            pulses++;
            check("hold_sum", {23'd0, cout8, sum8}, {23'd0, 1'b1, 8'h00});
            if (last_cyc >= 0) check("hold_period", 32'(k - last_cyc), 32'd10);
            last_cyc = k;
         end
      end
      start8 = 1'b0;
      check("hold_pulses", 32'(pulses), 32'd3);
      check("hold_overlap", 32'(overlap), 32'd0);
      tick();
      tick();

      // WIDTH=1 build: half-adder truth table
      run1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
      run1("w1_01", 1'b0, 1'b1, 1'b1, 1'b0);
      run1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
      run1("w1_11", 1'b1, 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
